mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DSize, default 32, meaning the data and address width.
REQ-002 SHALL have parameter TOUT, default 16, meaning the maximum wait cycles for mem_ready per access.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports IM_enable and IM_read, input, 1 bit each: instruction fetch request when both are 1.
REQ-006 SHALL have ports IM_addr (input, DSize) for the fetch address and IM_out (output, DSize) for the registered fetch data.
REQ-007 SHALL have ports DM_enable, DM_read and DM_write, input, 1 bit each: data request when DM_enable=1 and (DM_read=1 or DM_write=1).
REQ-008 SHALL have ports DM_addr and DM_in (input, DSize) for data address and write data, and DM_out (output, DSize) for registered read data.
REQ-009 SHALL have ports mem_cs and mem_we, output, 1 bit each: shared memory port select and write strobe.
REQ-010 SHALL have ports mem_addr and mem_wdata, output, DSize each: shared memory port address and write data.
REQ-011 SHALL have ports mem_rdata (input, DSize) and mem_ready (input, 1 bit): shared memory port read data and access-complete flag.
REQ-012 SHALL have port CPU_STALL, output, 1 bit: the CPU holds all state and request inputs while it is 1.
REQ-013 SHALL have port bus_err, output, 1 bit: sticky timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, IM_BUSY, DM_BUSY and DONE.
REQ-015 In IDLE, when any request is present, SHALL latch im_need and dm_need from the current requests and go to the first granted BUSY state.
REQ-016 When both requests are present, SHALL grant round-robin: the requester not granted first in the previous window goes first; last_grant resets to DM, so IM goes first after reset.
REQ-017 On BUSY entry SHALL register mem_addr, mem_wdata and mem_we from the granted requester.
REQ-018 Register sources: IM uses IM_addr with mem_we=0; DM uses DM_addr and DM_in with mem_we=DM_write (write wins if DM_read and DM_write are both 1).
REQ-019 SHALL hold mem_cs=1 in IM_BUSY and DM_BUSY up to and including the cycle mem_ready is sampled 1, and 0 in IDLE and DONE.
REQ-020 On mem_ready=1 in IM_BUSY SHALL load IM_out from mem_rdata.
REQ-021 On mem_ready=1 in DM_BUSY with a read SHALL load DM_out from mem_rdata; a DM write leaves DM_out unchanged.
REQ-022 After an access completes, SHALL go directly to the other BUSY state if its need flag is set and it is unserved; otherwise go to DONE. Back-to-back accesses are allowed with no idle cycle.
REQ-023 DONE SHALL last exactly one cycle with CPU_STALL=0, then go to IDLE; requests are ignored in DONE.
REQ-024 CPU_STALL SHALL equal (state==IDLE and any request present) or state is IM_BUSY or DM_BUSY.
REQ-025 Minimum window: request in IDLE, then BUSY with immediate mem_ready, then DONE, giving exactly 2 stall cycles.
REQ-026 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle with mem_ready=0.
REQ-027 When the wait counter reaches TOUT-1 with mem_ready still 0, SHALL abort the access: load the target data register with all-ones (reads only), set bus_err=1, and continue as if mem_ready=1.
REQ-028 bus_err SHALL stay 1 until reset.
REQ-029 mem_ready in IDLE or DONE SHALL be ignored.

Reset
REQ-030 While rst=0 at a clock edge, SHALL set: state=IDLE, mem_cs, mem_we, mem_addr, mem_wdata, IM_out, DM_out and bus_err all 0, last_grant=DM, wait counter 0, need flags 0.
REQ-031 CPU_STALL SHALL be 0 during reset regardless of requests.
REQ-032 Reset mid-access SHALL abandon the access; no data register is updated by a mem_ready arriving in the reset cycle.

Verification
REQ-033 Fetch only: IM_addr=0x40, mem_ready asserted 1 cycle after mem_cs, mem_rdata=0x12345678 -> mem_cs for 2 cycles, CPU_STALL for 3 cycles, IM_out=0x12345678 in DONE.
REQ-034 Simultaneous fetch and load after reset: IM_addr=0x10, DM_addr=0x800, immediate mem_ready -> mem_addr 0x10 then 0x800 on consecutive cycles, both registers loaded, 3 stall cycles. A second identical window serves DM first.
REQ-035 Store: DM_write=1, DM_addr=0x804, DM_in=0xCAFEF00D -> mem_we=1 with mem_wdata=0xCAFEF00D, DM_out unchanged.
REQ-036 Timeout: DM read with mem_ready held 0 -> abort after TOUT-1 wait cycles, DM_out=0xFFFFFFFF, bus_err=1 and held, then DONE.
REQ-037 Reset mid-access: rst=0 during DM_BUSY with mem_ready=1 -> next cycle IDLE, mem_cs=0, DM_out=0, CPU_STALL=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch (IM) and data (DM).
// Handshake: a request is held while CPU_STALL=1; an access completes in the BUSY cycle where mem_ready=1 or the wait budget expires.
module mem_arbiter #(
  parameter int DSize = 32,
  parameter int TOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IM_enable,
  input  logic             IM_read,
  input  logic [DSize-1:0] IM_addr,
  output logic [DSize-1:0] IM_out,
  input  logic             DM_enable,
  input  logic             DM_read,
  input  logic             DM_write,
  input  logic [DSize-1:0] DM_addr,
  input  logic [DSize-1:0] DM_in,
  output logic [DSize-1:0] DM_out,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [DSize-1:0] mem_addr,
  output logic [DSize-1:0] mem_wdata,
  input  logic [DSize-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             CPU_STALL,
  output logic             bus_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IM_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CW = $clog2(TOUT) + 1;

  state_t          state;
  logic            im_need;
  logic            dm_need;
  logic            last_grant_dm;
  logic [CW-1:0]   wait_cnt;

  logic            im_req;
  logic            dm_req;
  logic            any_req;
  logic            timeout;
  logic            finish;
  logic            im_first;

  assign im_req   = IM_enable & IM_read;
  assign dm_req   = DM_enable & (DM_read | DM_write);
  assign any_req  = im_req | dm_req;
  // IM goes first unless DM also asks and IM led the previous window.
  assign im_first = im_req & (~dm_req | last_grant_dm);

  assign timeout  = ~mem_ready && (wait_cnt == CW'(TOUT - 1));
  assign finish   = mem_ready | timeout;

  assign CPU_STALL = rst & (((state == IDLE) & any_req) |
                            (state == IM_BUSY) | (state == DM_BUSY));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      mem_cs        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      IM_out        <= '0;
      DM_out        <= '0;
      bus_err       <= 1'b0;
      last_grant_dm <= 1'b1;
      wait_cnt      <= '0;
      im_need       <= 1'b0;
      dm_need       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            im_need  <= im_req;
            dm_need  <= dm_req;
            wait_cnt <= '0;
            mem_cs   <= 1'b1;
            if (im_first) begin
              state         <= IM_BUSY;
              last_grant_dm <= 1'b0;
              mem_addr      <= IM_addr;
              mem_wdata     <= '0;
              mem_we        <= 1'b0;
            end else begin
              state         <= DM_BUSY;
              last_grant_dm <= 1'b1;
              mem_addr      <= DM_addr;
              mem_wdata     <= DM_in;
              mem_we        <= DM_write;
            end
          end
        end

        IM_BUSY: begin
          if (finish) begin
            IM_out   <= mem_ready ? mem_rdata : '1;
            im_need  <= 1'b0;
            wait_cnt <= '0;
            if (timeout) bus_err <= 1'b1;
            if (dm_need) begin
              state     <= DM_BUSY;
              mem_addr  <= DM_addr;
              mem_wdata <= DM_in;
              mem_we    <= DM_write;
            end else begin
              state  <= DONE;
              mem_cs <= 1'b0;
              mem_we <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        DM_BUSY: begin
          if (finish) begin
            // Writes leave the read-data register alone, even on timeout.
            if (!mem_we) DM_out <= mem_ready ? mem_rdata : '1;
            dm_need  <= 1'b0;
            wait_cnt <= '0;
            if (timeout) bus_err <= 1'b1;
            if (im_need) begin
              state     <= IM_BUSY;
              mem_addr  <= IM_addr;
              mem_wdata <= '0;
              mem_we    <= 1'b0;
            end else begin
              state  <= DONE;
              mem_cs <= 1'b0;
              mem_we <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        DONE: begin
          state   <= IDLE;
          im_need <= 1'b0;
          dm_need <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory responder drives mem_ready with a programmable delay
// and the expected address sequence of each window is held in a queue.
module tb_mem_arbiter;

  localparam int DSize = 32;
  localparam int TOUT  = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd3;

  logic             clk;
  logic             rst;
  logic             IM_enable;
  logic             IM_read;
  logic [DSize-1:0] IM_addr;
  logic [DSize-1:0] IM_out;
  logic             DM_enable;
  logic             DM_read;
  logic             DM_write;
  logic [DSize-1:0] DM_addr;
  logic [DSize-1:0] DM_in;
  logic [DSize-1:0] DM_out;
  logic             mem_cs;
  logic             mem_we;
  logic [DSize-1:0] mem_addr;
  logic [DSize-1:0] mem_wdata;
  logic [DSize-1:0] mem_rdata;
  logic             mem_ready;
  logic             CPU_STALL;
  logic             bus_err;
  logic [1:0]       dbg_state;

  int n_total;
  int n_pass;
  int stall_n;
  int cs_n;
  logic             last_we;
  logic [DSize-1:0] last_wdata;
  logic [DSize-1:0] exp_q[$];

  mem_arbiter #(.DSize(DSize), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .IM_enable(IM_enable), .IM_read(IM_read), .IM_addr(IM_addr), .IM_out(IM_out),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_addr(DM_addr), .DM_in(DM_in), .DM_out(DM_out),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .CPU_STALL(CPU_STALL), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DSize-1:0] rdata_for(input logic [DSize-1:0] a);
    if (a == 32'h40) return 32'h1234_5678;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign mem_rdata = rdata_for(mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    IM_enable = 1'b0; IM_read = 1'b0;
    DM_enable = 1'b0; DM_read = 1'b0; DM_write = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_reqs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Runs one window from IDLE until DONE is observed; inputs were set by the caller.
  task automatic run_window(input int delay, input int max_cyc);
    int  k;
    bit  done;
    stall_n = 0;
    cs_n    = 0;
    k       = 0;
    done    = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      mem_ready = mem_cs && (k >= delay);
      #1;
      if (CPU_STALL) stall_n++;
      if (mem_cs) begin
        cs_n++;
        if (mem_ready) begin
          last_we    = mem_we;
          last_wdata = mem_wdata;
          if (exp_q.size() == 0) check("unexpected_access", 64'(mem_addr), 64'hDEAD);
          else check("mem_addr", 64'(mem_addr), 64'(exp_q.pop_front()));
          k = 0;
        end else begin
          k++;
        end
      end
      if (dbg_state == S_DONE) done = 1'b1;
      else tick();
    end
    if (!done) check("window_bound", 64'd0, 64'd1);
  endtask

  // Leave DONE with requests dropped and confirm the return to IDLE.
  task automatic finish_window();
    clear_reqs();
    tick();
    check("idle_after_done", 64'(dbg_state), 64'(S_IDLE));
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    last_we   = 1'b0;
    last_wdata = '0;
    IM_addr = '0; DM_addr = '0; DM_in = '0;
    clear_reqs();
    rst = 1'b0;

    // Reset with a request pending: no stall, everything cleared.
    IM_enable = 1'b1; IM_read = 1'b1;
    tick();
    tick();
    check("rst_stall", 64'(CPU_STALL), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("rst_cs", 64'(mem_cs), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_im_out", 64'(IM_out), 64'd0);
    check("rst_dm_out", 64'(DM_out), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    clear_reqs();
    rst = 1'b1;
    tick();

    // Fetch only, memory answers one cycle after select.
    IM_enable = 1'b1; IM_read = 1'b1; IM_addr = 32'h40;
    exp_q.push_back(32'h40);
    run_window(1, 40);
    check("fetch_stall", 64'(stall_n), 64'd3);
    check("fetch_cs", 64'(cs_n), 64'd2);
    check("fetch_we", 64'(last_we), 64'd0);
    check("fetch_im_out", 64'(IM_out), 64'h1234_5678);
    check("fetch_done_cs", 64'(mem_cs), 64'd0);
    finish_window();

    // Simultaneous fetch and load after reset: IM first, then DM.
    do_reset();
    tick();
    IM_enable = 1'b1; IM_read = 1'b1; IM_addr = 32'h10;
    DM_enable = 1'b1; DM_read = 1'b1; DM_addr = 32'h800;
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h800);
    run_window(0, 40);
    check("both1_stall", 64'(stall_n), 64'd3);
    check("both1_cs", 64'(cs_n), 64'd2);
    check("both1_im_out", 64'(IM_out), 64'h5A5A_0010);
    check("both1_dm_out", 64'(DM_out), 64'h5A5A_0800);
    check("both1_q_empty", 64'(exp_q.size()), 64'd0);
    finish_window();

    // Same window again: round-robin puts DM first.
    IM_enable = 1'b1; IM_read = 1'b1; IM_addr = 32'h10;
    DM_enable = 1'b1; DM_read = 1'b1; DM_addr = 32'h800;
    exp_q.push_back(32'h800);
    exp_q.push_back(32'h10);
    run_window(0, 40);
    check("both2_stall", 64'(stall_n), 64'd3);
    check("both2_q_empty", 64'(exp_q.size()), 64'd0);
    finish_window();

    // Store: minimum two-cycle stall window, read-data register untouched.
    DM_enable = 1'b1; DM_write = 1'b1; DM_addr = 32'h804; DM_in = 32'hCAFE_F00D;
    exp_q.push_back(32'h804);
    run_window(0, 40);
    check("store_stall", 64'(stall_n), 64'd2);
    check("store_cs", 64'(cs_n), 64'd1);
    check("store_we", 64'(last_we), 64'd1);
    check("store_wdata", 64'(last_wdata), 64'hCAFE_F00D);
    check("store_dm_out", 64'(DM_out), 64'h5A5A_0800);
    finish_window();

    // Timeout: mem_ready never comes.
    DM_enable = 1'b1; DM_read = 1'b1; DM_addr = 32'h900;
    run_window(1000, 100);
    check("tout_cs", 64'(cs_n), 64'(TOUT));
    check("tout_stall", 64'(stall_n), 64'(TOUT + 1));
    check("tout_dm_out", 64'(DM_out), 64'hFFFF_FFFF);
    check("tout_bus_err", 64'(bus_err), 64'd1);
    finish_window();

    // bus_err is sticky across a good access.
    IM_enable = 1'b1; IM_read = 1'b1; IM_addr = 32'h40;
    exp_q.push_back(32'h40);
    run_window(0, 40);
    check("sticky_stall", 64'(stall_n), 64'd2);
    check("sticky_bus_err", 64'(bus_err), 64'd1);
    check("sticky_im_out", 64'(IM_out), 64'h1234_5678);
    finish_window();

    // Reset mid-access with mem_ready arriving in the reset cycle.
    DM_enable = 1'b1; DM_read = 1'b1; DM_addr = 32'h808;
    tick();
    check("mid_cs_busy", 64'(mem_cs), 64'd1);
    mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_stall", 64'(CPU_STALL), 64'd0);
    tick();
    check("mid_state", 64'(dbg_state), 64'(S_IDLE));
    check("mid_cs", 64'(mem_cs), 64'd0);
    check("mid_dm_out", 64'(DM_out), 64'd0);
    check("mid_bus_err", 64'(bus_err), 64'd0);
    check("mid_stall", 64'(CPU_STALL), 64'd0);
    rst = 1'b1;
    clear_reqs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
